// File: rtl/alu_op_sequencer.sv
// Multi-cycle R-type sequencer: accept -> READ -> EXEC -> WB, driving shared ALU and register file.
// Optional perf counters enabled by macro ALU_SEQ_PERF_EN; otherwise perf outputs are tied to zero.
module alu_op_sequencer #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [4:0]       rf_ra1,
    output logic [4:0]       rf_ra2,
    input  logic [W-1:0]     rf_rd1,
    input  logic [W-1:0]     rf_rd2,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [3:0]       alu_op,
    input  logic [W-1:0]     alu_result,
    output logic             rf_we,
    output logic [4:0]       rf_wa,
    output logic [W-1:0]     rf_wd,
    output logic             done,
    output logic             illegal,
    output logic [31:0]      perf_instr,
    output logic [CNT_W-1:0] perf_illegal
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t       state_q, state_d;
    logic [3:0]   dec_op_q;
    logic         illegal_q;
    logic [4:0]   rd_q;
    logic [4:0]   rf_ra1_q, rf_ra2_q;
    logic [W-1:0] op_a_q, op_b_q;
    logic [3:0]   alu_op_q;
    logic [4:0]   rf_wa_q;
    logic [W-1:0] rf_wd_q;

    logic         accept;
    logic         dec_legal;
    logic         in_wb;
    logic         unused_shamt;

    assign unused_shamt = &{1'b0, instr[10:6]};

    always_comb begin
        dec_legal = 1'b0;
        if (instr[31:26] == 6'b000000) begin
            case (instr[5:0])
                6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b100110, 6'b100111, 6'b101010: dec_legal = 1'b1;
                default:                         dec_legal = 1'b0;
            endcase
        end
    end

    assign accept = instr_valid && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = dec_legal ? S_READ : S_WB;
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A reset arriving during WB must not leak a retirement.
    assign in_wb       = (state_q == S_WB) && !reset;
    assign instr_ready = (state_q == S_IDLE);
    assign done        = in_wb;
    assign illegal     = in_wb && illegal_q;
    assign rf_we       = in_wb && !illegal_q && (rf_wa_q != 5'd0);
    assign rf_ra1      = rf_ra1_q;
    assign rf_ra2      = rf_ra2_q;
    assign alu_a       = op_a_q;
    assign alu_b       = op_b_q;
    assign alu_op      = alu_op_q;
    assign rf_wa       = rf_wa_q;
    assign rf_wd       = (state_q == S_WB) ? alu_result : rf_wd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dec_op_q  <= 4'd0;
            illegal_q <= 1'b0;
            rd_q      <= 5'd0;
            rf_ra1_q  <= 5'd0;
            rf_ra2_q  <= 5'd0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            alu_op_q  <= 4'd0;
            rf_wa_q   <= 5'd0;
            rf_wd_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                illegal_q <= !dec_legal;
                rd_q      <= instr[15:11];
                dec_op_q  <= dec_legal ? instr[3:0] : 4'd0;
                if (dec_legal) begin
                    rf_ra1_q <= instr[25:21];
                    rf_ra2_q <= instr[20:16];
                end else begin
                    // Illegal words skip straight to WB, so load the WB view now.
                    alu_op_q <= 4'd0;
                    rf_wa_q  <= instr[15:11];
                end
            end
            if (state_q == S_EXEC) begin
                op_a_q   <= rf_rd1;
                op_b_q   <= rf_rd2;
                alu_op_q <= dec_op_q;
                rf_wa_q  <= rd_q;
            end
            if (state_q == S_WB) begin
                rf_wd_q <= alu_result;
            end
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [31:0]      perf_instr_q;
    logic [CNT_W-1:0] perf_illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_instr_q   <= 32'd0;
            perf_illegal_q <= '0;
        end else begin
            if (done) perf_instr_q <= perf_instr_q + 32'd1;
            if (illegal && !(&perf_illegal_q)) perf_illegal_q <= perf_illegal_q + 1'b1;
        end
    end

    assign perf_instr   = perf_instr_q;
    assign perf_illegal = perf_illegal_q;
`else
    assign perf_instr   = 32'd0;
    assign perf_illegal = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a synchronous register-file model and a behavioural ALU.
module tb_alu_op_sequencer;

    localparam int W     = 32;
    localparam int CNT_W = 16;
`ifdef ALU_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [4:0]       rf_ra1, rf_ra2;
    logic [W-1:0]     rf_rd1, rf_rd2;
    logic [W-1:0]     alu_a, alu_b;
    logic [3:0]       alu_op;
    logic [W-1:0]     alu_result;
    logic             rf_we;
    logic [4:0]       rf_wa;
    logic [W-1:0]     rf_wd;
    logic             done, illegal;
    logic [31:0]      perf_instr;
    logic [CNT_W-1:0] perf_illegal;

    int checks   = 0;
    int failures = 0;
    int exp_instr = 0;
    int exp_ill   = 0;

    logic [W-1:0] regs [32];

    alu_op_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .done(done), .illegal(illegal),
        .perf_instr(perf_instr), .perf_illegal(perf_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rf_rd1 <= regs[rf_ra1];
        rf_rd2 <= regs[rf_ra2];
    end

    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0010: alu_result = alu_a - alu_b;
            4'b0100: alu_result = alu_a & alu_b;
            4'b0101: alu_result = alu_a | alu_b;
            4'b0110: alu_result = alu_a ^ alu_b;
            4'b0111: alu_result = ~(alu_a | alu_b);
            4'b1010: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [5:0] funct);
        return {op, rs, rt, rd, 5'b00101, funct};
    endfunction

    task automatic check_perf(input string tag);
        check({tag, "_perf_instr"}, 64'(perf_instr), PERF ? 64'(exp_instr) : 64'd0);
        check({tag, "_perf_illegal"}, 64'(perf_illegal), PERF ? 64'(exp_ill) : 64'd0);
    endtask

    // Called from IDLE; returns in the cycle after WB.
    task automatic run_legal(input string tag, input logic [31:0] w, input logic [3:0] e_op,
                             input logic [31:0] e_a, input logic [31:0] e_b,
                             input logic [31:0] e_wd, input logic e_we);
        instr = w; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0; instr = 32'hFFFF_FFFF;
        check({tag, "_ra1"}, 64'(rf_ra1), 64'(w[25:21]));
        check({tag, "_ra2"}, 64'(rf_ra2), 64'(w[20:16]));
        check({tag, "_busy"}, 64'(instr_ready), 64'd0);
        tick();
        check({tag, "_exec_done"}, 64'(done), 64'd0);
        tick();
        check({tag, "_done"}, 64'({done, illegal}), 64'b10);
        check({tag, "_op"}, 64'(alu_op), 64'(e_op));
        check({tag, "_a"}, 64'(alu_a), 64'(e_a));
        check({tag, "_b"}, 64'(alu_b), 64'(e_b));
        check({tag, "_wa"}, 64'(rf_wa), 64'(w[15:11]));
        check({tag, "_wd"}, 64'(rf_wd), 64'(e_wd));
        check({tag, "_we"}, 64'(rf_we), 64'(e_we));
        exp_instr++;
        tick();
        check({tag, "_ready"}, 64'({instr_ready, done, rf_we}), 64'b100);
        check({tag, "_hold_op"}, 64'(alu_op), 64'(e_op));
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] w);
        instr = w; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check({tag, "_done"}, 64'({done, illegal, rf_we}), 64'b110);
        check({tag, "_op"}, 64'(alu_op), 64'd0);
        exp_instr++; exp_ill++;
        tick();
        check({tag, "_ready"}, 64'({instr_ready, done, illegal}), 64'b100);
        check_perf(tag);
    endtask

    initial begin
        int acc_cnt, done_cnt, last_acc, cyc;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[4] = 32'hF0F0_00FF;
        regs[5] = 32'h0FF0_0F0F;

        reset = 1'b1; instr_valid = 1'b0; instr = 32'd0;
        tick(); tick();
        reset = 1'b0;
        check("rst_ready", 64'(instr_ready), 64'd1);
        check("rst_flags", 64'({done, illegal, rf_we}), 64'd0);
        check("rst_regs", 64'({alu_op, rf_wa, rf_ra1, rf_ra2}), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_wd", 64'(rf_wd), 64'd0);
        check_perf("rst");

        run_legal("add", mk(6'd0, 5'd1, 5'd2, 5'd3, 6'b100000), 4'b0000, 32'd5, 32'd7, 32'd12, 1'b1);
        run_legal("sub", mk(6'd0, 5'd4, 5'd5, 5'd6, 6'b100010), 4'b0010,
                  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hE0FF_F1F0, 1'b1);
        run_legal("and", mk(6'd0, 5'd4, 5'd5, 5'd7, 6'b100100), 4'b0100,
                  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b1);
        run_legal("or",  mk(6'd0, 5'd4, 5'd5, 5'd8, 6'b100101), 4'b0101,
                  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b1);
        run_legal("xor", mk(6'd0, 5'd4, 5'd5, 5'd9, 6'b100110), 4'b0110,
                  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b1);
        run_legal("nor", mk(6'd0, 5'd4, 5'd5, 5'd10, 6'b100111), 4'b0111,
                  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000, 1'b1);
        run_legal("slt", mk(6'd0, 5'd4, 5'd5, 5'd11, 6'b101010), 4'b1010,
                  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd1, 1'b1);
        run_legal("slt_r", mk(6'd0, 5'd5, 5'd4, 5'd12, 6'b101010), 4'b1010,
                  32'h0FF0_0F0F, 32'hF0F0_00FF, 32'd0, 1'b1);
        run_legal("rd0", mk(6'd0, 5'd1, 5'd2, 5'd0, 6'b100000), 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);
        check_perf("legal");

        run_illegal("ill_funct", mk(6'd0, 5'd1, 5'd2, 5'd3, 6'b001000));
        run_illegal("ill_op", mk(6'b100011, 5'd1, 5'd2, 5'd3, 6'b100000));
        run_illegal("ill_addu", mk(6'd0, 5'd1, 5'd2, 5'd3, 6'b100001));

        // Reset during EXEC aborts without a retirement.
        instr = mk(6'd0, 5'd1, 5'd2, 5'd3, 6'b100000); instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("abort_1", 64'({instr_ready, done, rf_we}), 64'b100);
        tick();
        check("abort_2", 64'({instr_ready, done, rf_we}), 64'b100);
        reset = 1'b0;
        exp_instr = 0; exp_ill = 0;
        check("abort_alu_a", 64'(alu_a), 64'd0);
        check_perf("abort");
        tick(); tick(); tick();
        check("abort_quiet", 64'({instr_ready, done, rf_we}), 64'b100);

        // Continuous valid: one accept every four cycles.
        acc_cnt = 0; done_cnt = 0; last_acc = -4;
        instr_valid = 1'b1;
        for (cyc = 0; cyc < 16; cyc++) begin
            instr = mk(6'd0, 5'd1, 5'd2, 5'(cyc % 3 + 1), 6'b100000);
            if (done) done_cnt++;
            if (instr_ready) begin
                check("stream_gap", 64'(cyc - last_acc), 64'd4);
                last_acc = cyc;
                acc_cnt++;
            end
            tick();
        end
        instr_valid = 1'b0;
        check("stream_accepts", 64'(acc_cnt), 64'd4);
        check("stream_dones", 64'(done_cnt), 64'd4);
        exp_instr = 4;
        check_perf("stream");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
